// File: rtl/alu_arbiter_if.sv
// alu_arbiter_if: request, ALU and response signals of the ALU arbiter
interface alu_arbiter_if #(parameter int OP_W = 6);
  logic            req0_valid, req0_ready, req1_valid, req1_ready;
  logic [OP_W-1:0] req0_op, req1_op;
  logic [31:0]     req0_src1, req0_src2, req0_imm;
  logic [31:0]     req1_src1, req1_src2, req1_imm;
  logic [OP_W-1:0] alu_op;
  logic [31:0]     alu_src1, alu_src2, alu_imm, alu_result;
  logic            resp_valid, resp_id, resp_ready;
  logic [31:0]     resp_data;
  modport slave (
    input  req0_valid, req0_op, req0_src1, req0_src2, req0_imm,
    input  req1_valid, req1_op, req1_src1, req1_src2, req1_imm,
    output req0_ready, req1_ready,
    output alu_op, alu_src1, alu_src2, alu_imm,
    input  alu_result,
    output resp_valid, resp_id, resp_data,
    input  resp_ready
  );
  modport master (
    output req0_valid, req0_op, req0_src1, req0_src2, req0_imm,
    output req1_valid, req1_op, req1_src1, req1_src2, req1_imm,
    input  req0_ready, req1_ready,
    input  alu_op, alu_src1, alu_src2, alu_imm,
    output alu_result,
    input  resp_valid, resp_id, resp_data,
    output resp_ready
  );
endinterface

// File: rtl/alu_arbiter.sv
// alu_arbiter: two-requester round-robin arbiter feeding a two-stage ALU issue/result pipeline
module alu_arbiter #(parameter int OP_W = 6) (
  input logic clk,
  input logic rst,
  alu_arbiter_if.slave bus
);
  logic            s1_v, s1_id, s2_v, s2_id, last_grant;
  logic [OP_W-1:0] s1_op;
  logic [31:0]     s1_src1, s1_src2, s1_imm, s2_data;
  logic            s2_adv, s2_free, s1_adv, s1_free, g0, g1;
  // Stage advance chain and round-robin grant; on a tie the requester not granted last wins
  always_comb begin
    s2_adv  = s2_v & bus.resp_ready;
    s2_free = !s2_v | s2_adv;
    s1_adv  = s1_v & s2_free;
    s1_free = !s1_v | s1_adv;
    g0 = s1_free & bus.req0_valid & (!bus.req1_valid | last_grant);
    g1 = s1_free & bus.req1_valid & (!bus.req0_valid | !last_grant);
  end
  assign bus.req0_ready = g0;
  assign bus.req1_ready = g1;
  assign bus.alu_op     = s1_op;
  assign bus.alu_src1   = s1_src1;
  assign bus.alu_src2   = s1_src2;
  assign bus.alu_imm    = s1_imm;
  assign bus.resp_valid = s2_v;
  assign bus.resp_id    = s2_id;
  assign bus.resp_data  = s2_data;
  // Issue stage loads on a grant, result stage captures the ALU output when S1 advances
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_v       <= 1'b0;
      s1_id      <= 1'b0;
      s1_op      <= '0;
      s1_src1    <= '0;
      s1_src2    <= '0;
      s1_imm     <= '0;
      s2_v       <= 1'b0;
      s2_id      <= 1'b0;
      s2_data    <= '0;
      last_grant <= 1'b1;
    end else begin
      if (g0 | g1) begin
        s1_v       <= 1'b1;
        s1_id      <= g1;
        s1_op      <= g1 ? bus.req1_op : bus.req0_op;
        s1_src1    <= g1 ? bus.req1_src1 : bus.req0_src1;
        s1_src2    <= g1 ? bus.req1_src2 : bus.req0_src2;
        s1_imm     <= g1 ? bus.req1_imm : bus.req0_imm;
        last_grant <= g1;
      end else if (s1_adv) s1_v <= 1'b0;
      if (s1_adv) begin
        s2_v    <= 1'b1;
        s2_id   <= s1_id;
        s2_data <= bus.alu_result;
      end else if (s2_adv) s2_v <= 1'b0;
    end
  end
endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter: directed and randomized self-checking bench for alu_arbiter
module tb_alu_arbiter;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  alu_arbiter_if #(.OP_W(6)) bus();
  alu_arbiter #(.OP_W(6)) dut (.clk(clk), .rst(rst), .bus(bus.slave));
  int checks = 0;
  int errors = 0;
  logic [32:0] sb[$];
  logic [31:0] held_src1, held_data;
  logic fired;
  int p;

  function automatic logic [31:0] ref_alu(input logic [5:0] op, input logic [31:0] a, b, imm);
    case (op)
      6'd0:    return a + b;
      6'd1:    return a - b;
      6'd2:    return a & b;
      6'd3:    return a | b;
      6'd4:    return a ^ b;
      6'd5:    return a + imm;
      default: return 32'd0;
    endcase
  endfunction

  assign bus.alu_result = ref_alu(bus.alu_op, bus.alu_src1, bus.alu_src2, bus.alu_imm);

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic sample;
    logic [32:0] e;
    @(negedge clk);
    check("ready0_without_valid", 32'(bus.req0_ready & !bus.req0_valid), 0);
    check("ready1_without_valid", 32'(bus.req1_ready & !bus.req1_valid), 0);
    check("ready_both", 32'(bus.req0_ready & bus.req1_ready), 0);
    if (bus.resp_valid && bus.resp_ready) begin
      if (sb.size() == 0) check("resp_unexpected", 1, 0);
      else begin
        e = sb.pop_front();
        check("sb_resp_id", 32'(bus.resp_id), 32'(e[32]));
        check("sb_resp_data", bus.resp_data, e[31:0]);
      end
    end
    if (bus.req0_valid && bus.req0_ready)
      sb.push_back({1'b0, ref_alu(bus.req0_op, bus.req0_src1, bus.req0_src2, bus.req0_imm)});
    if (bus.req1_valid && bus.req1_ready)
      sb.push_back({1'b1, ref_alu(bus.req1_op, bus.req1_src1, bus.req1_src2, bus.req1_imm)});
  endtask

  task automatic adv;
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_reset;
    rst = 1'b1;
    sb.delete();
    adv();
    rst = 1'b0;
  endtask

  task automatic set0(input logic v, input logic [5:0] op, input logic [31:0] a, b, imm);
    bus.req0_valid = v; bus.req0_op = op; bus.req0_src1 = a; bus.req0_src2 = b; bus.req0_imm = imm;
  endtask

  task automatic set1(input logic v, input logic [5:0] op, input logic [31:0] a, b, imm);
    bus.req1_valid = v; bus.req1_op = op; bus.req1_src1 = a; bus.req1_src2 = b; bus.req1_imm = imm;
  endtask

  initial begin
    set0(0, 0, 0, 0, 0);
    set1(0, 0, 0, 0, 0);
    bus.resp_ready = 1'b0;
    #2;
    check("rst_resp_valid", 32'(bus.resp_valid), 0);
    check("rst_resp_id", 32'(bus.resp_id), 0);
    check("rst_resp_data", bus.resp_data, 0);
    check("rst_alu_op", 32'(bus.alu_op), 0);
    check("rst_alu_src1", bus.alu_src1, 0);
    check("rst_alu_src2", bus.alu_src2, 0);
    check("rst_alu_imm", bus.alu_imm, 0);
    adv();
    rst = 1'b0;
    // single op on an idle pipeline
    bus.resp_ready = 1'b1;
    set0(1, 0, 5, 7, 0);
    sample(); check("t1_ready0", 32'(bus.req0_ready), 1); adv();
    set0(0, 0, 0, 0, 0);
    sample(); check("t1_c1_resp_valid", 32'(bus.resp_valid), 0); adv();
    sample();
    check("t1_c2_resp_valid", 32'(bus.resp_valid), 1);
    check("t1_c2_resp_id", 32'(bus.resp_id), 0);
    check("t1_c2_resp_data", bus.resp_data, 12);
    adv();
    sample(); check("t1_c3_resp_valid", 32'(bus.resp_valid), 0); adv();
    // tie and strict alternation from reset
    pulse_reset();
    set0(1, 0, 1, 1, 0);
    set1(1, 1, 10, 3, 0);
    for (int k = 0; k < 6; k++) begin
      if (k == 4) begin set0(0, 0, 0, 0, 0); set1(0, 0, 0, 0, 0); end
      sample();
      if (k < 4) begin
        check("t2_ready0", 32'(bus.req0_ready), 32'(k % 2 == 0));
        check("t2_ready1", 32'(bus.req1_ready), 32'(k % 2 == 1));
      end
      if (k >= 2) begin
        check("t2_resp_valid", 32'(bus.resp_valid), 1);
        check("t2_resp_id", 32'(bus.resp_id), 32'(k % 2));
        check("t2_resp_data", bus.resp_data, (k % 2 == 1) ? 32'd7 : 32'd2);
      end
      adv();
    end
    // backpressure with hold stability, then release
    pulse_reset();
    bus.resp_ready = 1'b0;
    p = 0;
    set1(1, 0, 100, 0, 0);
    for (int k = 0; k < 8; k++) begin
      bus.resp_ready = (k >= 5);
      sample();
      check("t3_ready1", 32'(bus.req1_ready), 32'(k == 0 || k == 1 || k == 5));
      if (k == 2) begin held_src1 = bus.alu_src1; held_data = bus.resp_data; end
      if (k >= 2 && k <= 4) begin
        check("t3_stall_resp_valid", 32'(bus.resp_valid), 1);
        check("t3_hold_alu_src1", bus.alu_src1, held_src1);
        check("t3_hold_resp_data", bus.resp_data, held_data);
      end
      if (k >= 5) begin
        check("t3_resp_valid", 32'(bus.resp_valid), 1);
        check("t3_resp_data", bus.resp_data, 32'(100 + 2 * (k - 5)));
      end
      fired = bus.req1_ready;
      adv();
      if (fired) begin
        p++;
        if (p < 3) set1(1, 0, 32'(100 + p), 32'(p), 0);
        else set1(0, 0, 0, 0, 0);
      end
    end
    // reset with both stages full
    bus.resp_ready = 1'b0;
    set0(1, 2, 32'hff, 32'h0f, 0);
    sample(); adv();
    sample(); adv();
    set0(0, 0, 0, 0, 0);
    check("t5_full_resp_valid", 32'(bus.resp_valid), 1);
    rst = 1'b1;
    #1;
    check("t5_rst_resp_valid", 32'(bus.resp_valid), 0);
    check("t5_rst_alu_src1", bus.alu_src1, 0);
    sb.delete();
    adv();
    rst = 1'b0;
    set0(1, 0, 3, 4, 0);
    set1(1, 1, 9, 2, 0);
    sample();
    check("t5_tie_ready0", 32'(bus.req0_ready), 1);
    check("t5_tie_ready1", 32'(bus.req1_ready), 0);
    adv();
    set0(0, 0, 0, 0, 0);
    set1(0, 0, 0, 0, 0);
    bus.resp_ready = 1'b1;
    repeat (4) begin sample(); adv(); end
    // randomized traffic against the scoreboard
    for (int k = 0; k < 10000; k++) begin
      if (!bus.req0_valid && $urandom_range(0, 2) != 0)
        set0(1, 6'($urandom_range(0, 7)), $urandom, $urandom, $urandom);
      if (!bus.req1_valid && $urandom_range(0, 2) != 0)
        set1(1, 6'($urandom_range(0, 7)), $urandom, $urandom, $urandom);
      bus.resp_ready = ($urandom_range(0, 3) != 0);
      sample();
      fired = bus.req0_ready;
      p = int'(bus.req1_ready);
      adv();
      if (fired) bus.req0_valid = 1'b0;
      if (p != 0) bus.req1_valid = 1'b0;
    end
    set0(0, 0, 0, 0, 0);
    set1(0, 0, 0, 0, 0);
    bus.resp_ready = 1'b1;
    repeat (4) begin sample(); adv(); end
    check("sb_drained", 32'(sb.size()), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/alu_arbiter.md
# alu_arbiter

Two-requester round-robin arbiter and two-stage issue/result pipeline in front of the shared combinational integer ALU. Requester 0 is the execute stage; requester 1 is the auxiliary address/IO sequencer. The block registers the granted operation, presents it to the ALU, captures the result, and returns it tagged with the requester id under valid/ready backpressure. Sustained throughput is one operation per cycle.

## Interface
Parameters:
- OP_W, 6, width of the opaque ALU operation code; it passes through unchanged to the external ALU decoder.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- req0_valid / req1_valid  in  1  request present.
- req0_ready / req1_ready  out  1  request accepted this cycle (combinational grant).
- reqN_op  in  OP_W  operation code.
- reqN_src1, reqN_src2, reqN_imm  in  32 each  operands.
- alu_op  out  OP_W  registered stage-1 op.
- alu_src1, alu_src2, alu_imm  out  32 each  registered stage-1 operands.
- alu_result  in  32  combinational ALU result for the alu_* values.
- resp_valid  out  1  result available.
- resp_id  out  1  requester that owns resp_data.
- resp_data  out  32  result.
- resp_ready  in  1  consumer takes the response.

## Operation
- State:
  - Stage 1 (S1): s1_v, s1_id, and the op/operand registers, which drive alu_*.
  - Stage 2 (S2): s2_v, s2_id, s2_data, which drive resp_*.
  - last_grant: 1 bit.
- Advance conditions:
  - s2_adv = s2_v & resp_ready (S2 empties).
  - s2_free = !s2_v | s2_adv.
  - s1_adv = s1_v & s2_free.
  - s1_free = !s1_v | s1_adv.
- Arbitration happens only when s1_free:
  - If only one requester is valid, it is granted.
  - If both are valid, the requester != last_grant is granted.
  - If none is valid, there is no grant.
  - reqN_ready = s1_free & granted_N.
  - At most one ready is high per cycle.
  - A ready may assert only while the matching valid is high.
- On a grant:
  - S1 loads {1, id, op, src1, src2, imm}.
  - last_grant <= id.
- On s1_adv:
  - S2 loads {1, s1_id, alu_result}.
  - If there is no new grant that cycle, s1_v <= 0.
- On s2_adv with no s1_adv: s2_v <= 0.
- Held state:
  - S1 and S2 contents hold while stalled.
  - alu_* hold while S1 is stalled, so the ALU result stays stable.
  - After S1 drains, alu_* keep their last values (don't-care).
- resp_data is 32-bit and passed unmodified. Op codes unknown to the decoder yield whatever the ALU returns (0 by the ALU default path).
- Requesters must hold valid and payload until ready. The arbiter does not drop a pending request.

## Timing
- Reset (asynchronous, immediate):
  - s1_v = s2_v = 0.
  - resp_valid = 0, resp_id = 0, resp_data = 0.
  - alu_op = 0, alu_src1 = alu_src2 = alu_imm = 0.
  - last_grant = 1, so requester 0 wins the first tie.
  - reqN_ready is then driven purely by reqN_valid under the grant rule.
- Latency:
  - Request accepted at edge E.
  - alu_* valid after E.
  - Result captured at E+1.
  - resp_valid high from after E+1 until the handshake edge.
  - Minimum request-to-response is 2 edges.
- Back-to-back: with resp_ready held high, one grant per cycle and one response per cycle.
- Full: S1 and S2 both valid with resp_ready = 0 gives both reqN_ready = 0. In the cycle resp_ready rises, S2 drains, S1 moves to S2, and a new grant is taken, all at the same edge.
- Fairness: with both requesters valid continuously, grants alternate strictly 0,1,0,1…
- Reset mid-operation: all in-flight S1/S2 contents are discarded. No response is issued for them.
- resp_ready while resp_valid = 0 is ignored.

## Test plan
- Single op, idle pipeline: req0 op = add, src1 = 5, src2 = 7 at cycle 0, resp_ready = 1 → req0_ready = 1 in cycle 0; resp_valid = 1, resp_id = 0, resp_data = 12 in cycle 2 only.
- Tie and alternation: both valid for 4 cycles, req0 = add 1+1, req1 = sub 10-3, resp_ready = 1 → grants 0,1,0,1; responses in cycles 2–5 carry (id, data) = (0,2), (1,7), (0,2), (1,7).
- Backpressure: resp_ready = 0 with 3 requests offered from req1 → 2 accepted (cycles 0, 1), then req1_ready = 0. Raising resp_ready at cycle 5 → responses in cycles 5, 6, 7 in order; third request accepted in cycle 5.
- Hold stability: during the stall in the previous test, alu_* and resp_data stay constant cycle to cycle.
- Reset mid-flight: assert rst with S1 and S2 valid → resp_valid = 0 immediately. After release, the first tie grants requester 0.
- Random: 10k cycles of random valids, random resp_ready, and a reference ALU model → no lost, duplicated or reordered responses; per-id results match; no ready asserted without the matching valid.
